iir_sample_feeder: RTL and testbench
====================================

Name: iir_sample_feeder

Overview:
- Upstream stage of the first-order IIR (y = x + 0.5*y_prev, 6-bit).
- Buffers incoming 6-bit samples from a valid/ready source in a small FIFO.
- Releases them to the IIR `inp` port at a programmable, fixed cadence.
- Sequences the filter's initial-condition load (`in_cd`), so the IIR sees one clean, evenly spaced sample stream.

Parameters:
- DATA_W, 6, sample width; matches IIR `inp`/`in_cd`.
- DEPTH, 8, FIFO entries; power of two.
- RATE_W, 4, width of the cadence register.
- PRIME_LVL, 2, FIFO occupancy required before streaming starts.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_W  upstream sample.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  FIFO can accept a sample.
- run  in  1  streaming enable (level).
- rate  in  RATE_W  clocks between output samples, minus 1.
- ic_value  in  DATA_W  initial-condition value for the IIR.
- ic_load  in  1  single-cycle request to load `ic_value`.
- inp  out  DATA_W  sample to the IIR.
- inp_valid  out  1  one-cycle strobe; `inp` is new this cycle.
- in_cd  out  DATA_W  initial condition to the IIR.
- in_cd_valid  out  1  one-cycle strobe; `in_cd` is new this cycle.
- count  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underrun  out  1  one-cycle pulse: tick occurred with the FIFO empty in RUN.

Behaviour:
- Reset (rst=1 at an edge):
  - All outputs go to 0; FIFO is emptied; state = IDLE.
  - Tick counter is loaded with `rate`.
  - Applies mid-operation too: a reset during RUN discards the FIFO contents.
- FIFO write:
  - s_ready = (count < DEPTH), driven from registered count.
  - A push occurs when s_valid && s_ready.
  - When full, there is no pass-through, even if a pop occurs in the same cycle.
- Overflow: s_valid && !s_ready sets `overflow`; it is cleared only by rst.
- Pop:
  - Occurs only on a tick in RUN with registered count > 0.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Tick counter:
  - Active only in RUN; counts down from `rate` and reloads when it reaches 0.
  - A tick is asserted on the cycle the counter equals 0.
  - rate=0 gives a tick every cycle; rate=15 gives one tick per 16 cycles.
  - `rate` is sampled only at reload.
- Output register:
  - On a tick with a pop, `inp` = FIFO head and inp_valid=1 on the next cycle.
  - At all other times inp_valid=0 and `inp` holds its last value.
- Latency: a sample pushed at cycle N into an empty FIFO (state RUN, tick at N+1) appears on `inp` at N+2.
- Underrun: a tick in RUN with count=0 gives underrun=1 on the next cycle, inp_valid=0, no pop; state stays RUN.
- State machine:
  - IDLE: counter held at `rate`, no pops. run=1 -> PRIME.
  - PRIME: no pops. count >= PRIME_LVL -> RUN, with the counter loaded with `rate`; the first tick comes rate+1 cycles after entry.
  - RUN: streaming as above.
  - Any state with run=0 -> IDLE next cycle. FIFO contents are preserved and writes continue.
- Initial condition:
  - ic_load=1 in any state registers ic_value into `in_cd`, with in_cd_valid=1 for one cycle.
  - In RUN, ic_load also reloads the tick counter with `rate`, and any tick in that same cycle is suppressed (no pop, no underrun).
  - ic_load therefore restarts the cadence, so the IIR state is replaced before the next sample.
- Simultaneous events:
  - rst outranks everything.
  - ic_load outranks tick.
  - run=0 outranks a PRIME->RUN transition.

Decomposition:
- Package `iir_pkg`:
  - DATA_W constant, shared with the IIR.
  - Feeder state enum {IDLE, PRIME, RUN}.
  - Default DEPTH, RATE_W and PRIME_LVL constants.
- Sub-module `iir_sync_fifo`:
  - Synchronous FIFO parameterized by DATA_W and DEPTH.
  - Ports: push, pop, wdata, rdata, count, full, empty.
  - Same clock/rst convention.
- Tick counter, FSM and output registers stay in the top module.

Test Plan:
1. Reset, then push 2,4,6,3, rate=1, run=1 -> PRIME exits at count=2; inp_valid pulses every 2 cycles with inp 2,4,6,3; count returns to 0.
2. Hold s_valid with 10 samples and run=0 -> count=8, s_ready=0, overflow=1 and stays 1 until rst; the first 8 samples stream in order once run=1.
3. rate=0, run=1, supply 3 samples then stop -> 3 back-to-back inp_valid cycles, then underrun pulses every cycle with inp holding 3.
4. ic_load=1 with ic_value=1 on the same cycle as a tick in RUN -> in_cd=1 and in_cd_valid=1 next cycle, no inp_valid that cycle, next inp_valid exactly rate+2 cycles after ic_load.
5. rst=1 for one cycle mid-stream with count=5 -> next cycle count=0, inp=0, inp_valid=0, overflow=0, state IDLE; a push of 2 followed by run=1 resumes only after count reaches 2.
6. Push and tick together with count=8 and rate=0 -> count stays 8 and s_ready stays 0 (no pass-through); after the tick, count=7 and s_ready=1.

Source files
------------

// File: rtl/iir_pkg.sv
// -----------------------------------------------------------------------------
// iir_pkg
// Shared constants and types for the first-order IIR and its sample feeder.
//   DATA_W         : sample / initial-condition width used by the IIR
//   DEPTH_DEF      : default feeder FIFO depth (power of two)
//   RATE_W_DEF     : default width of the output cadence register
//   PRIME_LVL_DEF  : default FIFO occupancy needed before streaming
//   feeder_state_e : feeder sequencing states
// -----------------------------------------------------------------------------
package iir_pkg;

  localparam int DATA_W        = 6;
  localparam int DEPTH_DEF     = 8;
  localparam int RATE_W_DEF    = 4;
  localparam int PRIME_LVL_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/iir_sync_fifo.sv
// -----------------------------------------------------------------------------
// iir_sync_fifo
// Single-clock FIFO with registered occupancy. Pushes are ignored while full
// and pops are ignored while empty; there is no write-to-read pass-through.
// Ports:
//   clock, rst : rising-edge clock, synchronous active-high reset
//   push/wdata : write request and data
//   pop/rdata  : read request; rdata always shows the current head entry
//   count      : occupancy 0..DEPTH
//   full/empty : decoded from the registered occupancy
// -----------------------------------------------------------------------------
module iir_sync_fifo #(
  parameter int DATA_W = iir_pkg::DATA_W,
  parameter int DEPTH  = iir_pkg::DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push_s;
  logic              do_pop_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == {CW{1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers (wrap naturally, DEPTH is a power of two) and occupancy.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/iir_sample_feeder.sv
// -----------------------------------------------------------------------------
// iir_sample_feeder
// Buffers upstream samples and releases them to the IIR at a fixed cadence of
// one sample per (rate+1) clocks, and forwards initial-condition loads.
// Ports:
//   clock, rst            : rising-edge clock, synchronous active-high reset
//   s_data/s_valid/s_ready: upstream valid/ready sample interface
//   run                   : streaming enable (level)
//   rate                  : clocks between output samples minus one
//   ic_value/ic_load      : initial-condition value and one-cycle load request
//   inp/inp_valid         : sample to the IIR with one-cycle strobe
//   in_cd/in_cd_valid     : initial condition to the IIR with one-cycle strobe
//   count                 : FIFO occupancy
//   overflow              : sticky, write attempted while full
//   underrun              : one-cycle pulse, cadence tick found the FIFO empty
// -----------------------------------------------------------------------------
module iir_sample_feeder
  import iir_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int RATE_W    = RATE_W_DEF,
  parameter int PRIME_LVL = PRIME_LVL_DEF,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              run,
  input  logic [RATE_W-1:0] rate,
  input  logic [DATA_W-1:0] ic_value,
  input  logic              ic_load,
  output logic [DATA_W-1:0] inp,
  output logic              inp_valid,
  output logic [DATA_W-1:0] in_cd,
  output logic              in_cd_valid,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underrun
);

  feeder_state_e     state_q, state_d;
  logic [RATE_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [DATA_W-1:0] inp_q;
  logic              inp_valid_q;
  logic [DATA_W-1:0] in_cd_q;
  logic              in_cd_valid_q;
  logic              overflow_q;
  logic              underrun_q;

  logic [DATA_W-1:0] fifo_rdata_s;
  logic [CW-1:0]     fifo_count_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              pop_s;
  logic              tick_s;

  // ic_load restarts the cadence, so it swallows a tick in the same cycle.
  assign tick_s  = (state_q == ST_RUN) && (tick_cnt_q == {RATE_W{1'b0}}) && !ic_load;
  assign s_ready = !fifo_full_s;
  assign push_s  = s_valid && s_ready;
  assign pop_s   = tick_s && !fifo_empty_s;

  iir_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (s_data),
    .rdata (fifo_rdata_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next-state and cadence counter. Outside RUN the counter tracks `rate`, so
  // entering RUN starts a full period.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    case (state_q)
      ST_IDLE: begin
        tick_cnt_d = rate;
        if (run) begin
          state_d = ST_PRIME;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRIME: begin
        tick_cnt_d = rate;
        if (!run) begin
          state_d = ST_IDLE;
        end else if (fifo_count_s >= CW'(PRIME_LVL)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PRIME;
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
        if (ic_load || (tick_cnt_q == {RATE_W{1'b0}})) begin
          tick_cnt_d = rate;
        end else begin
          tick_cnt_d = tick_cnt_q - RATE_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tick_cnt_d = rate;
      end
    endcase
  end

  // State, cadence counter and all registered outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tick_cnt_q    <= rate;
      inp_q         <= {DATA_W{1'b0}};
      inp_valid_q   <= 1'b0;
      in_cd_q       <= {DATA_W{1'b0}};
      in_cd_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      inp_valid_q   <= pop_s;
      underrun_q    <= tick_s && fifo_empty_s;
      in_cd_valid_q <= ic_load;
      if (pop_s) begin
        inp_q <= fifo_rdata_s;
      end
      if (ic_load) begin
        in_cd_q <= ic_value;
      end
      if (s_valid && !s_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign inp         = inp_q;
  assign inp_valid   = inp_valid_q;
  assign in_cd       = in_cd_q;
  assign in_cd_valid = in_cd_valid_q;
  assign count       = fifo_count_s;
  assign overflow    = overflow_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_iir_sample_feeder.sv
// -----------------------------------------------------------------------------
// tb_iir_sample_feeder
// Directed bench: a per-cycle vector table for the basic streaming and
// back-to-back/underrun cases, then hand-written sequences for overflow,
// full-FIFO tick, initial-condition load and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_iir_sample_feeder;

  logic       clock = 1'b0;
  logic       rst;
  logic [5:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       run;
  logic [3:0] rate;
  logic [5:0] ic_value;
  logic       ic_load;
  logic [5:0] inp;
  logic       inp_valid;
  logic [5:0] in_cd;
  logic       in_cd_valid;
  logic [3:0] count;
  logic       overflow;
  logic       underrun;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  iir_sample_feeder dut (
    .clock       (clock),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .run         (run),
    .rate        (rate),
    .ic_value    (ic_value),
    .ic_load     (ic_load),
    .inp         (inp),
    .inp_valid   (inp_valid),
    .in_cd       (in_cd),
    .in_cd_valid (in_cd_valid),
    .count       (count),
    .overflow    (overflow),
    .underrun    (underrun)
  );

  typedef struct {
    logic       r;
    logic [5:0] d;
    logic       v;
    logic       run;
    logic [3:0] rate;
    logic [3:0] e_cnt;
    logic       e_iv;
    logic [5:0] e_inp;
    logic       e_und;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic r, input logic [5:0] d, input logic v, input logic rn,
                     input logic [3:0] rt, input logic [3:0] ec, input logic eiv,
                     input logic [5:0] einp, input logic eund);
    vec_t t;
    t.r = r; t.d = d; t.v = v; t.run = rn; t.rate = rt;
    t.e_cnt = ec; t.e_iv = eiv; t.e_inp = einp; t.e_und = eund;
    tbl.push_back(t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int got;
    int seen;
    rst = 1'b1; s_data = 6'd0; s_valid = 1'b0; run = 1'b0; rate = 4'd1;
    ic_value = 6'd0; ic_load = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_inp_valid", inp_valid, 0);
    chk("rst_inp", inp, 0);
    chk("rst_in_cd", in_cd, 0);
    chk("rst_in_cd_valid", in_cd_valid, 0);
    chk("rst_underrun", underrun, 0);

    // Stream 2,4,6,3 at rate=1, then one underrun
    add(1, 0, 0, 0, 1,  0, 0, 0, 0);
    add(0, 2, 1, 1, 1,  1, 0, 0, 0);
    add(0, 4, 1, 1, 1,  2, 0, 0, 0);
    add(0, 6, 1, 1, 1,  3, 0, 0, 0);
    add(0, 3, 1, 1, 1,  4, 0, 0, 0);
    add(0, 0, 0, 1, 1,  3, 1, 2, 0);
    add(0, 0, 0, 1, 1,  3, 0, 2, 0);
    add(0, 0, 0, 1, 1,  2, 1, 4, 0);
    add(0, 0, 0, 1, 1,  2, 0, 4, 0);
    add(0, 0, 0, 1, 1,  1, 1, 6, 0);
    add(0, 0, 0, 1, 1,  1, 0, 6, 0);
    add(0, 0, 0, 1, 1,  0, 1, 3, 0);
    add(0, 0, 0, 1, 1,  0, 0, 3, 0);
    add(0, 0, 0, 1, 1,  0, 0, 3, 1);
    // rate=0: three back-to-back samples, then underrun every cycle
    add(1, 0, 0, 0, 0,  0, 0, 0, 0);
    add(0, 7, 1, 1, 0,  1, 0, 0, 0);
    add(0, 8, 1, 1, 0,  2, 0, 0, 0);
    add(0, 9, 1, 1, 0,  3, 0, 0, 0);
    add(0, 0, 0, 1, 0,  2, 1, 7, 0);
    add(0, 0, 0, 1, 0,  1, 1, 8, 0);
    add(0, 0, 0, 1, 0,  0, 1, 9, 0);
    add(0, 0, 0, 1, 0,  0, 0, 9, 1);
    add(0, 0, 0, 1, 0,  0, 0, 9, 1);

    foreach (tbl[i]) begin
      rst = tbl[i].r; s_data = tbl[i].d; s_valid = tbl[i].v;
      run = tbl[i].run; rate = tbl[i].rate;
      step();
      chk($sformatf("vec%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("vec%0d_inp_valid", i), inp_valid, tbl[i].e_iv);
      chk($sformatf("vec%0d_inp", i), inp, tbl[i].e_inp);
      chk($sformatf("vec%0d_underrun", i), underrun, tbl[i].e_und);
    end
    rst = 1'b0; s_valid = 1'b0; run = 1'b0;

    // Overflow with 10 samples, then full-FIFO tick, then ordered drain
    rate = 4'd0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = 6'(10 + i);
      step();
    end
    chk("ovf_count", count, 8);
    chk("ovf_s_ready", s_ready, 0);
    chk("ovf_flag", overflow, 1);
    s_data = 6'd63; run = 1'b1;
    step();
    step();
    chk("full_count_before_tick", count, 8);
    chk("full_s_ready_before_tick", s_ready, 0);
    step();
    s_valid = 1'b0;
    chk("full_count_after_tick", count, 7);
    chk("full_s_ready_after_tick", s_ready, 1);
    chk("full_first_valid", inp_valid, 1);
    chk("full_first_inp", inp, 10);
    got = 1;
    for (int c = 0; c < 20 && got < 8; c++) begin
      step();
      if (inp_valid) begin
        chk($sformatf("drain_inp%0d", got), inp, 10 + got);
        got++;
      end
    end
    chk("drain_samples", got, 8);
    chk("ovf_sticky", overflow, 1);
    run = 1'b0;
    do_reset();
    chk("ovf_cleared", overflow, 0);

    // ic_load coinciding with a tick at rate=2
    rate = 4'd2;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 6'(20 + i);
      step();
    end
    s_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      step();
      if (inp_valid) seen = 1;
    end
    chk("ic_first_seen", seen, 1);
    chk("ic_first_inp", inp, 20);
    step();
    step();
    ic_load = 1'b1; ic_value = 6'd1;
    step();
    ic_load = 1'b0;
    chk("ic_in_cd", in_cd, 1);
    chk("ic_in_cd_valid", in_cd_valid, 1);
    chk("ic_no_inp_valid", inp_valid, 0);
    chk("ic_no_underrun", underrun, 0);
    chk("ic_count_held", count, 3);
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 1) chk("ic_valid_drop", in_cd_valid, 0);
      if (k < 3) begin
        chk($sformatf("ic_wait%0d_iv", k), inp_valid, 0);
      end else begin
        chk("ic_resume_iv", inp_valid, 1);
        chk("ic_resume_inp", inp, 21);
      end
    end
    run = 1'b0;

    // Mid-stream reset with count=5, then re-prime
    rate = 4'd0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1; s_data = 6'(40 + i);
      step();
    end
    s_valid = 1'b0; run = 1'b1;
    step();
    step();
    step();
    chk("mid_count", count, 5);
    chk("mid_inp", inp, 40);
    rst = 1'b1;
    step();
    rst = 1'b0; run = 1'b0;
    chk("mrst_count", count, 0);
    chk("mrst_inp", inp, 0);
    chk("mrst_inp_valid", inp_valid, 0);
    chk("mrst_overflow", overflow, 0);
    chk("mrst_s_ready", s_ready, 1);
    s_valid = 1'b1; s_data = 6'd33;
    step();
    s_valid = 1'b0; run = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (inp_valid) seen++;
    end
    chk("prime_hold_no_output", seen, 0);
    s_valid = 1'b1; s_data = 6'd34;
    step();
    s_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      step();
      if (inp_valid) seen = 1;
    end
    chk("resume_seen", seen, 1);
    chk("resume_inp", inp, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
